psw_stacked: RTL and testbench
==============================

// Module: psw_stacked
// PURPOSE
//  Parametrised processor status word with a save/restore LIFO for interrupt entry/return.
//  Holds condition-code flags Z/N/C/V plus an interrupt-enable bit, loadable from and drivable to the shared tri-state DATA bus.
//  Condition codes update from the ALU comparator on qualifying ALU instructions.
//  PUSH (interrupt entry) saves the word and clears IE; POP (RTI) restores the saved word.
// PARAMETERS
//  DATA_W       16  bus / status word width (>= 16)
//  STACK_DEPTH   4  saved-word LIFO entries (>= 1)
//  IE_BIT       15  bit index of interrupt-enable flag
// PORTS
//  clk           in     1        system clock, rising edge
//  reset         in     1        asynchronous, active-low reset
//  DATA          inout  DATA_W   shared bus; driven only when enable=1, else Z
//  REG_OUT_PSW   out    DATA_W   current status word, always driven
//  latch         in     1        load status word from DATA
//  enable        in     1        drive status word onto DATA
//  IR_opcode     in     4        instruction opcode
//  IR_S          in     1        instruction set-flags bit
//  Z_in          in     1        control-unit CC write strobe
//  ALU_control   in     3        ALU operation select
//  CC_Z_in, CC_N_in, CC_C_in, CC_V_in  in 1 each  comparator/ALU flag results
//  push          in     1        save word to LIFO, clear IE
//  pop           in     1        restore word from LIFO
//  clr_err       in     1        clear sticky error flags
//  stack_full    out    1        LIFO holds STACK_DEPTH entries
//  stack_empty   out    1        LIFO holds 0 entries
//  stack_level   out    $clog2(STACK_DEPTH+1)  entry count
//  ovf_err       out    1        sticky: push while full, or push+pop together
//  unf_err       out    1        sticky: pop while empty
// BEHAVIOUR
//  - reset low (async): word=0, LIFO empty (level=0), ovf_err=unf_err=0; entries contents don't-care.
//  - Status word bits: 0 Z, 1 N, 2 C, 3 V, IE_BIT IE; other bits plain storage.
//  - Priority per clk edge (one action only): latch > pop > push > CC update.
//  - latch: word<=DATA; LIFO untouched; any push/pop/CC that cycle is dropped without error.
//  - pop, level>0: word<=top entry, level-1. pop, level=0: word held, unf_err<=1.
//  - push, level<STACK_DEPTH: entry[level]<=word, word[IE_BIT]<=0, level+1.
//    push, full: nothing stored, word held (IE unchanged), ovf_err<=1.
//  - push and pop same cycle: pop executes as above, push dropped, ovf_err<=1.
//  - CC update qualifier: IR_opcode<=5 && IR_S && Z_in && ALU_control!=3'b010 && !=3'b111.
//    ALU_control 000/001 (add/sub): Z,N,C,V all written. Other qualifying ops: Z,N written, C,V held.
//    All non-flag bits held.
//  - Latency: every update visible on REG_OUT_PSW/DATA one cycle after the edge; DATA drive is combinational from enable.
//  - stack_full/empty/level registered consistently with LIFO state (no lag).
//  - clr_err: both sticky errors <=0; an error event in the same cycle wins (flag set).
//  - Reset mid-operation: immediate clear regardless of clk; no partial write survives.
// STRUCTURE
//  - Shared package fpg8_pkg: PSW bit indices (PSW_Z=0, PSW_N=1, PSW_C=2, PSW_V=3), ALU_control codes (ALU_ADD, ALU_SUB, ALU_MOV=3'b010, ALU_PASS=3'b111), ALU_OP_MAX=5.
//  - Sub-module psw_lifo (params WIDTH, DEPTH): storage array, level counter, full/empty, do_push/do_pop strobes already arbitrated by the parent.
//  - Parent owns priority arbitration, CC decode, IE clear, sticky errors, tri-state.
// TESTING
//  - reset low mid-cycle with word=16'hFFFF, level=2 -> word=0, level=0, stack_empty=1, errors 0 without clk edge.
//  - latch=1 DATA=16'h800F; enable=1 next cycle -> DATA reads 16'h800F; enable=0 -> DATA=Z, REG_OUT_PSW=16'h800F.
//  - word=0, opcode=2 IR_S=1 Z_in=1 ALU_control=000, Z,N,C,V=1,0,1,1 -> word=16'h000D; repeat ALU_control=011 flags 0,1,0,0 -> 16'h000E; ALU_control=010 -> unchanged.
//  - word=16'h8003, push x4 (DEPTH=4) -> level 4, full=1, IE=0; 5th push -> ovf_err=1, level 4; pop x4 -> word=16'h8003 after last, empty=1; extra pop -> unf_err=1.
//  - push+pop same cycle, level=1 entry 16'h8001, word 16'h0002 -> word=16'h8001, level=0, ovf_err=1; clr_err -> both errors 0.
//  - latch with push and qualifying CC update same cycle -> word=DATA, level unchanged, no error.

Source files
------------

// File: rtl/fpg8_pkg.sv
// Shared constants for the status-word block: PSW flag bit positions,
// ALU_control encodings and the condition-code update decode helpers.
package fpg8_pkg;

    localparam int PSW_Z = 0;
    localparam int PSW_N = 1;
    localparam int PSW_C = 2;
    localparam int PSW_V = 3;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MOV  = 3'b010;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam logic [3:0] ALU_OP_MAX = 4'd5;

    // MOV and PASS move data without a meaningful comparison,
    // so they never touch the flags.
    function automatic logic cc_qualify(input logic [3:0] opcode,
                                        input logic       set_flags,
                                        input logic       cc_strobe,
                                        input logic [2:0] alu_ctl);
        return (opcode <= ALU_OP_MAX) && set_flags && cc_strobe &&
               (alu_ctl != ALU_MOV) && (alu_ctl != ALU_PASS);
    endfunction

    // Only add/sub produce valid carry and overflow.
    function automatic logic cc_full_write(input logic [2:0] alu_ctl);
        return (alu_ctl == ALU_ADD) || (alu_ctl == ALU_SUB);
    endfunction

endpackage

// File: rtl/psw_stacked_if.sv
// Control/status bundle between the control unit (master) and the status
// word block (slave). The shared DATA bus is a resolved tri-state net and
// stays a plain inout on the block.
//   master drives: latch, enable, IR_opcode, IR_S, Z_in, ALU_control,
//                  CC_*_in, push, pop, clr_err
//   slave drives : REG_OUT_PSW, stack_full, stack_empty, stack_level,
//                  ovf_err, unf_err
interface psw_stacked_if #(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic              latch;
    logic              enable;
    logic [3:0]        IR_opcode;
    logic              IR_S;
    logic              Z_in;
    logic [2:0]        ALU_control;
    logic              CC_Z_in;
    logic              CC_N_in;
    logic              CC_C_in;
    logic              CC_V_in;
    logic              push;
    logic              pop;
    logic              clr_err;

    logic [DATA_W-1:0] REG_OUT_PSW;
    logic              stack_full;
    logic              stack_empty;
    logic [LVL_W-1:0]  stack_level;
    logic              ovf_err;
    logic              unf_err;

    modport master (
        output latch, enable, IR_opcode, IR_S, Z_in, ALU_control,
               CC_Z_in, CC_N_in, CC_C_in, CC_V_in, push, pop, clr_err,
        input  REG_OUT_PSW, stack_full, stack_empty, stack_level,
               ovf_err, unf_err
    );

    modport slave (
        input  latch, enable, IR_opcode, IR_S, Z_in, ALU_control,
               CC_Z_in, CC_N_in, CC_C_in, CC_V_in, push, pop, clr_err,
        output REG_OUT_PSW, stack_full, stack_empty, stack_level,
               ovf_err, unf_err
    );

endinterface

// File: rtl/psw_lifo.sv
// Saved-status-word LIFO. Push/pop strobes arrive already arbitrated and
// never assert together, and never push when full or pop when empty.
//   clk, reset (async active-low)
//   do_push, push_data : store push_data at entry[level]
//   do_pop             : drop the top entry
//   top_data           : entry[level-1] (don't-care when empty)
//   level, full, empty : occupancy, registered together
module psw_lifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         do_push,
    input  logic                         do_pop,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             top_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LVL_W-1:0] level_nxt;

    always_comb begin
        level_nxt = level;
        if (do_push)
            level_nxt = level + LVL_W'(1);
        else if (do_pop)
            level_nxt = level - LVL_W'(1);
    end

    // Flags are derived from the next level so they never lag the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            level <= level_nxt;
            full  <= (level_nxt == LVL_W'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    // Storage needs no reset; the write is gated so nothing lands while
    // reset is asserted.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset && do_push && (level == LVL_W'(i)))
                mem[i] <= push_data;
        end
    end

    always_comb begin
        top_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level == LVL_W'(i + 1))
                top_data = mem[i];
        end
    end

endmodule

// File: rtl/psw_stacked.sv
// Processor status word (Z/N/C/V + IE) with save/restore LIFO for
// interrupt entry and return.
//   clk, reset (async active-low)
//   DATA : shared tri-state bus; driven with the word while enable=1
//   bus  : control/status bundle (slave side), see psw_stacked_if
// One action per edge: latch > pop > push > condition-code update.
module psw_stacked
    import fpg8_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4,
    parameter int IE_BIT      = 15
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire [DATA_W-1:0]  DATA,
    psw_stacked_if.slave      bus
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] word_nxt;
    logic [DATA_W-1:0] top_data;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;
    logic              ovf_set;
    logic              unf_set;
    logic              ovf_err;
    logic              unf_err;

    always_comb begin
        word_nxt = word;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (bus.latch) begin
            // Everything else this cycle is silently dropped.
            word_nxt = DATA;
        end else if (bus.pop) begin
            if (empty) begin
                unf_set = 1'b1;
            end else begin
                do_pop   = 1'b1;
                word_nxt = top_data;
            end
            // A push colliding with a pop is lost and reported.
            if (bus.push)
                ovf_set = 1'b1;
        end else if (bus.push) begin
            if (full) begin
                ovf_set = 1'b1;
            end else begin
                do_push          = 1'b1;
                word_nxt[IE_BIT] = 1'b0;
            end
        end else if (cc_qualify(bus.IR_opcode, bus.IR_S, bus.Z_in, bus.ALU_control)) begin
            word_nxt[PSW_Z] = bus.CC_Z_in;
            word_nxt[PSW_N] = bus.CC_N_in;
            if (cc_full_write(bus.ALU_control)) begin
                word_nxt[PSW_C] = bus.CC_C_in;
                word_nxt[PSW_V] = bus.CC_V_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word    <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            word    <= word_nxt;
            // A new error event outranks a clear in the same cycle.
            ovf_err <= ovf_set | (ovf_err & ~bus.clr_err);
            unf_err <= unf_set | (unf_err & ~bus.clr_err);
        end
    end

    psw_lifo #(
        .WIDTH (DATA_W),
        .DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk       (clk),
        .reset     (reset),
        .do_push   (do_push),
        .do_pop    (do_pop),
        .push_data (word),
        .top_data  (top_data),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    assign DATA            = bus.enable ? word : 'z;
    assign bus.REG_OUT_PSW = word;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_level = level;
    assign bus.ovf_err     = ovf_err;
    assign bus.unf_err     = unf_err;

endmodule

// File: tb/tb_psw_stacked.sv
module tb_psw_stacked;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] drv = '0;
    logic        drv_en = 1'b0;
    wire  [15:0] data_bus;

    int tests = 0;
    int fails = 0;

    assign data_bus = drv_en ? drv : 'z;

    psw_stacked_if #(.DATA_W(DATA_W), .STACK_DEPTH(DEPTH)) bus ();

    psw_stacked #(.DATA_W(DATA_W), .STACK_DEPTH(DEPTH), .IE_BIT(15)) dut (
        .clk   (clk),
        .reset (rst_n),
        .DATA  (data_bus),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.latch = 0; bus.enable = 0; bus.push = 0; bus.pop = 0; bus.clr_err = 0;
        bus.IR_opcode = 0; bus.IR_S = 0; bus.Z_in = 0; bus.ALU_control = 0;
        bus.CC_Z_in = 0; bus.CC_N_in = 0; bus.CC_C_in = 0; bus.CC_V_in = 0;
        drv_en = 0;
    endtask

    task automatic load(input logic [15:0] v);
        drv = v; drv_en = 1; bus.latch = 1;
        step();
        bus.latch = 0; drv_en = 0;
    endtask

    task automatic cc(input logic [3:0] op, input logic s, input logic zi,
                      input logic [2:0] alu, input logic [3:0] vnzc);
        bus.IR_opcode = op; bus.IR_S = s; bus.Z_in = zi; bus.ALU_control = alu;
        {bus.CC_V_in, bus.CC_C_in, bus.CC_N_in, bus.CC_Z_in} = vnzc;
        step();
        idle();
    endtask

    initial begin
        idle();
        #12;
        chk("rst_word", 32'(bus.REG_OUT_PSW), 32'h0);
        chk("rst_level", 32'(bus.stack_level), 32'd0);
        chk("rst_empty", 32'(bus.stack_empty), 32'd1);
        chk("rst_full", 32'(bus.stack_full), 32'd0);
        chk("rst_errs", 32'({bus.ovf_err, bus.unf_err}), 32'd0);
        rst_n = 1;
        step();

        // latch and bus drive
        load(16'h800F);
        chk("latch_word", 32'(bus.REG_OUT_PSW), 32'h800F);
        bus.enable = 1; #1;
        chk("drive_on", 32'(data_bus), 32'h800F);
        bus.enable = 0; drv = 16'h1234; drv_en = 1; #1;
        chk("drive_off_release", 32'(data_bus), 32'h1234);
        drv_en = 0;
        step();
        chk("word_after_release", 32'(bus.REG_OUT_PSW), 32'h800F);

        // condition codes; vnzc = {V,C,N,Z}
        load(16'h0000);
        cc(4'd2, 1, 1, 3'b000, 4'b1101);
        chk("cc_add", 32'(bus.REG_OUT_PSW), 32'h000D);
        cc(4'd2, 1, 1, 3'b011, 4'b0010);
        chk("cc_other_zn_only", 32'(bus.REG_OUT_PSW), 32'h000E);
        cc(4'd2, 1, 1, 3'b010, 4'b1111);
        chk("cc_mov_hold", 32'(bus.REG_OUT_PSW), 32'h000E);
        cc(4'd2, 1, 1, 3'b111, 4'b1111);
        chk("cc_pass_hold", 32'(bus.REG_OUT_PSW), 32'h000E);
        cc(4'd6, 1, 1, 3'b000, 4'b1111);
        chk("cc_op6_hold", 32'(bus.REG_OUT_PSW), 32'h000E);
        cc(4'd2, 0, 1, 3'b000, 4'b1111);
        chk("cc_nos_hold", 32'(bus.REG_OUT_PSW), 32'h000E);
        cc(4'd2, 1, 0, 3'b000, 4'b1111);
        chk("cc_nozin_hold", 32'(bus.REG_OUT_PSW), 32'h000E);
        cc(4'd1, 1, 1, 3'b001, 4'b0000);
        chk("cc_sub_clear", 32'(bus.REG_OUT_PSW), 32'h0000);
        cc(4'd5, 1, 1, 3'b100, 4'b1111);
        chk("cc_op5_zn", 32'(bus.REG_OUT_PSW), 32'h0003);

        // push to full, overflow, pop to empty, underflow
        load(16'h8003);
        bus.push = 1;
        step();
        chk("push1_ie_clr", 32'(bus.REG_OUT_PSW), 32'h0003);
        chk("push1_level", 32'(bus.stack_level), 32'd1);
        step(); step(); step();
        chk("push4_level", 32'(bus.stack_level), 32'd4);
        chk("push4_full", 32'(bus.stack_full), 32'd1);
        chk("push4_ovf", 32'(bus.ovf_err), 32'd0);
        step();
        chk("push5_ovf", 32'(bus.ovf_err), 32'd1);
        chk("push5_level", 32'(bus.stack_level), 32'd4);
        chk("push5_word", 32'(bus.REG_OUT_PSW), 32'h0003);
        bus.push = 0; bus.pop = 1;
        step();
        chk("pop1_level", 32'(bus.stack_level), 32'd3);
        chk("pop1_full", 32'(bus.stack_full), 32'd0);
        step(); step(); step();
        chk("pop4_word", 32'(bus.REG_OUT_PSW), 32'h8003);
        chk("pop4_empty", 32'(bus.stack_empty), 32'd1);
        chk("pop4_unf", 32'(bus.unf_err), 32'd0);
        step();
        chk("pop5_unf", 32'(bus.unf_err), 32'd1);
        chk("pop5_word", 32'(bus.REG_OUT_PSW), 32'h8003);
        // clear racing a new underflow: the event wins
        bus.clr_err = 1;
        step();
        chk("clr_vs_unf", 32'({bus.ovf_err, bus.unf_err}), 32'b01);
        bus.pop = 0;
        step();
        chk("clr_both", 32'({bus.ovf_err, bus.unf_err}), 32'b00);
        bus.clr_err = 0;

        // push and pop together
        load(16'h8001);
        bus.push = 1; step(); bus.push = 0;
        load(16'h0002);
        chk("pp_pre_level", 32'(bus.stack_level), 32'd1);
        bus.push = 1; bus.pop = 1;
        step();
        idle();
        chk("pp_word", 32'(bus.REG_OUT_PSW), 32'h8001);
        chk("pp_level", 32'(bus.stack_level), 32'd0);
        chk("pp_errs", 32'({bus.ovf_err, bus.unf_err}), 32'b10);
        bus.clr_err = 1; step(); bus.clr_err = 0;
        chk("pp_clr", 32'({bus.ovf_err, bus.unf_err}), 32'b00);

        // latch outranks push, pop and CC, with no error
        drv = 16'h1234; drv_en = 1; bus.latch = 1; bus.push = 1; bus.pop = 1;
        bus.IR_opcode = 2; bus.IR_S = 1; bus.Z_in = 1; bus.ALU_control = 3'b000;
        {bus.CC_V_in, bus.CC_C_in, bus.CC_N_in, bus.CC_Z_in} = 4'b1111;
        step();
        idle();
        chk("latch_prio_word", 32'(bus.REG_OUT_PSW), 32'h1234);
        chk("latch_prio_level", 32'(bus.stack_level), 32'd0);
        chk("latch_prio_errs", 32'({bus.ovf_err, bus.unf_err}), 32'b00);

        // asynchronous reset mid-cycle
        bus.push = 1; step(); step(); step();
        bus.pop = 1; step();
        idle();
        load(16'hFFFF);
        chk("pre_rst_level", 32'(bus.stack_level), 32'd2);
        chk("pre_rst_ovf", 32'(bus.ovf_err), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("arst_word", 32'(bus.REG_OUT_PSW), 32'h0);
        chk("arst_level", 32'(bus.stack_level), 32'd0);
        chk("arst_empty", 32'(bus.stack_empty), 32'd1);
        chk("arst_errs", 32'({bus.ovf_err, bus.unf_err}), 32'b00);
        step();
        rst_n = 1;
        step();
        chk("post_rst_word", 32'(bus.REG_OUT_PSW), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
